// File: rtl/pic10_pkg.sv
// Shared definitions for the PIC10F200-compatible sequencer: FSM states,
// opcode field prefixes and reset defaults.
package pic10_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam int unsigned     PC_W_DEFAULT      = 9;
    localparam logic [8:0]      RESET_VEC_DEFAULT = 9'h1FF;

    // ir[11:5] prefixes
    localparam logic [6:0] OP7_NOP   = 7'b0000000;
    localparam logic [6:0] OP7_MOVWF = 7'b0000001;
    // ir[11:6] prefixes
    localparam logic [5:0] OP6_DECFSZ = 6'b001011;
    localparam logic [5:0] OP6_INCFSZ = 6'b001111;
    // ir[11:8] prefixes
    localparam logic [3:0] OP4_BCF   = 4'b0100;
    localparam logic [3:0] OP4_BSF   = 4'b0101;
    localparam logic [3:0] OP4_BTFSC = 4'b0110;
    localparam logic [3:0] OP4_BTFSS = 4'b0111;
    localparam logic [3:0] OP4_RETLW = 4'b1000;
    localparam logic [3:0] OP4_CALL  = 4'b1001;
    localparam logic [3:0] OP4_MOVLW = 4'b1100;
    // ir[11:9] prefix
    localparam logic [2:0] OP3_GOTO  = 3'b101;

    function automatic logic [7:0] bit_mask(input logic [2:0] b);
        return 8'b0000_0001 << b;
    endfunction

endpackage

// File: rtl/pic10_stack.sv
// Two-level return stack: push shifts s1 into s2 (old s2 lost), pop moves
// s2 into s1 and leaves s2 in place so repeated pops keep returning it.
module pic10_stack
    import pic10_pkg::*;
#(
    parameter int unsigned WIDTH = PC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else if (push) begin
            s2 <= s1;
            s1 <= din;
        end else if (pop) begin
            s1 <= s2;
        end
    end

    assign top = s1;

endmodule

// File: rtl/pic10_seq_ctrl.sv
// PIC10F200 instruction sequencer: three-cycle FETCH/LOAD/EXEC loop that
// decodes ir, steers the external ALU result and handles branches/skips.
module pic10_seq_ctrl
    import pic10_pkg::*;
#(
    parameter int unsigned       PC_W      = PC_W_DEFAULT,
    parameter logic [PC_W-1:0]   RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [PC_W-1:0] pm_addr,
    input  logic [11:0]     pm_data,
    output logic [4:0]      rf_addr,
    input  logic [7:0]      rf_rdata,
    output logic [7:0]      rf_wdata,
    output logic            rf_we,
    output logic [11:0]     alu_opcode,
    output logic [7:0]      alu_f,
    output logic [7:0]      alu_w,
    input  logic [7:0]      alu_r,
    output logic [7:0]      w_out,
    output logic [PC_W-1:0] pc_out
);

    state_t          state;
    state_t          state_next;
    logic [11:0]     ir;
    logic [7:0]      w;
    logic [7:0]      w_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_top;
    logic            push;
    logic            pop;

    assign pc_inc     = pc + PC_W'(1);
    assign rf_addr    = ir[4:0];
    assign alu_opcode = ir;
    assign alu_f      = rf_rdata;
    assign alu_w      = w;
    assign w_out      = w;
    assign pc_out     = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:   state_next = en ? LOAD : FETCH;
            LOAD:    state_next = EXEC;
            EXEC:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Write strobe and data are combinational from EXEC so an async reset
    // mid-instruction suppresses the write immediately.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        w_next   = w;
        pc_next  = pc;
        push     = 1'b0;
        pop      = 1'b0;
        if (state == EXEC) begin
            if (ir[11:10] == 2'b00) begin
                if (ir[11:5] == OP7_MOVWF) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_r;
                end else if (ir[11:5] != OP7_NOP) begin
                    if (ir[5]) begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_r;
                    end else begin
                        w_next = alu_r;
                    end
                    if ((ir[11:6] == OP6_DECFSZ || ir[11:6] == OP6_INCFSZ) && alu_r == 8'h00)
                        pc_next = pc_inc;
                end
            end else if (ir[11:9] == OP3_GOTO) begin
                pc_next = ir[PC_W-1:0];
            end else begin
                unique case (ir[11:8])
                    OP4_BCF: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata & ~bit_mask(ir[7:5]);
                    end
                    OP4_BSF: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata | bit_mask(ir[7:5]);
                    end
                    OP4_BTFSC: if (!rf_rdata[ir[7:5]]) pc_next = pc_inc;
                    OP4_BTFSS: if (rf_rdata[ir[7:5]])  pc_next = pc_inc;
                    OP4_RETLW: begin
                        w_next  = ir[7:0];
                        pc_next = stack_top;
                        pop     = 1'b1;
                    end
                    OP4_CALL: begin
                        push    = 1'b1;
                        pc_next = PC_W'({1'b0, ir[7:0]});
                    end
                    OP4_MOVLW: w_next = ir[7:0];
                    default:   w_next = alu_r;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VEC;
            pm_addr <= RESET_VEC;
            ir      <= '0;
            w       <= '0;
        end else begin
            unique case (state)
                FETCH: pm_addr <= pc;
                LOAD: begin
                    ir <= pm_data;
                    pc <= pc_inc;
                end
                EXEC: begin
                    pc <= pc_next;
                    w  <= w_next;
                end
                default: ;
            endcase
        end
    end

    pic10_stack #(
        .WIDTH(PC_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .top   (stack_top)
    );

endmodule

// File: tb/tb_pic10_seq_ctrl.sv
// Bench for pic10_seq_ctrl: ROM, register file and ALU models around the DUT,
// table vectors, hand-written corner sequences and a random program run.
module tb_pic10_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [8:0]  pm_addr;
    logic [11:0] pm_data;
    logic [4:0]  rf_addr;
    logic [7:0]  rf_rdata;
    logic [7:0]  rf_wdata;
    logic        rf_we;
    logic [11:0] alu_opcode;
    logic [7:0]  alu_f;
    logic [7:0]  alu_w;
    logic [7:0]  alu_r;
    logic [7:0]  w_out;
    logic [8:0]  pc_out;

    logic [11:0] rom [512];
    logic [7:0]  rf  [32];

    int n_vec = 0;
    int n_err = 0;

    pic10_seq_ctrl #(
        .PC_W      (9),
        .RESET_VEC (9'h1FF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .rf_addr    (rf_addr),
        .rf_rdata   (rf_rdata),
        .rf_wdata   (rf_wdata),
        .rf_we      (rf_we),
        .alu_opcode (alu_opcode),
        .alu_f      (alu_f),
        .alu_w      (alu_w),
        .alu_r      (alu_r),
        .w_out      (w_out),
        .pc_out     (pc_out)
    );

    // External ALU behaviour (10F200 byte/literal ops, carry ignored)
    function automatic logic [7:0] alu_fn(input logic [7:0] f, input logic [7:0] wv,
                                          input logic [11:0] op);
        logic [7:0] k;
        k = op[7:0];
        if (op[11:10] == 2'b00) begin
            case (op[9:6])
                4'd0:  return wv;
                4'd1:  return 8'h00;
                4'd2:  return f - wv;
                4'd3:  return f - 8'd1;
                4'd4:  return f | wv;
                4'd5:  return f & wv;
                4'd6:  return f ^ wv;
                4'd7:  return f + wv;
                4'd8:  return f;
                4'd9:  return ~f;
                4'd10: return f + 8'd1;
                4'd11: return f - 8'd1;
                4'd12: return {1'b0, f[7:1]};
                4'd13: return {f[6:0], 1'b0};
                4'd14: return {f[3:0], f[7:4]};
                default: return f + 8'd1;
            endcase
        end
        case (op[11:8])
            4'hD:    return wv | k;
            4'hE:    return wv & k;
            4'hF:    return wv ^ k;
            default: return 8'h00;
        endcase
    endfunction

    assign pm_data  = rom[pm_addr];
    assign rf_rdata = rf[rf_addr];
    assign alu_r    = alu_fn(alu_f, alu_w, alu_opcode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) rom[i] = 12'h000;
        for (int i = 0; i < 32; i++)  rf[i]  = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One instruction from FETCH: counts rf_we cycles, captures the write in
    // EXEC, reports the fetch address and commits the write to the reg file.
    task automatic retire(output int cnt, output logic [4:0] wa, output logic [7:0] wd,
                          output logic [8:0] fa);
        cnt = 0; wa = '0; wd = '0;
        @(posedge clk); @(negedge clk);
        fa = pm_addr;
        if (rf_we) cnt++;
        @(posedge clk); @(negedge clk);
        if (rf_we) begin cnt++; wa = rf_addr; wd = rf_wdata; end
        @(posedge clk); @(negedge clk);
        if (rf_we) cnt++;
        if (cnt != 0) rf[wa] = wd;
    endtask

    typedef struct {
        logic [11:0] instr;
        logic [7:0]  w0;
        logic [7:0]  f0;
        int          exp_we;
        logic [7:0]  exp_wd;
        logic [7:0]  exp_w;
        logic [8:0]  exp_pc;
    } vec_t;

    // Reference model state
    logic [7:0] m_rf [32];
    logic [7:0] m_w;
    logic [8:0] m_pc;
    logic [8:0] m_q [$];

    task automatic model_step(output int we, output logic [4:0] wa, output logic [7:0] wd);
        logic [11:0] op;
        logic [7:0]  fv, r, k;
        logic [2:0]  b;
        op = rom[m_pc];
        m_pc = m_pc + 9'd1;
        wa = op[4:0]; fv = m_rf[wa]; b = op[7:5]; k = op[7:0];
        r  = alu_fn(fv, m_w, op);
        we = 0; wd = 8'h00;
        casez (op)
            12'b0000000?????: ;
            12'b0000001?????: begin we = 1; wd = r; end
            12'b00??????????: begin
                if (op[5]) begin we = 1; wd = r; end
                else m_w = r;
                if ((op[11:6] == 6'b001011 || op[11:6] == 6'b001111) && r == 8'h00)
                    m_pc = m_pc + 9'd1;
            end
            12'b0100????????: begin we = 1; wd = fv & ~(8'(8'd1 << b)); end
            12'b0101????????: begin we = 1; wd = fv | 8'(8'd1 << b); end
            12'b0110????????: if (!fv[b]) m_pc = m_pc + 9'd1;
            12'b0111????????: if (fv[b])  m_pc = m_pc + 9'd1;
            12'b1000????????: begin m_w = k; m_pc = m_q[0]; m_q[0] = m_q[1]; end
            12'b1001????????: begin
                m_q.push_front(m_pc);
                void'(m_q.pop_back());
                m_pc = {1'b0, k};
            end
            12'b101?????????: m_pc = op[8:0];
            12'b1100????????: m_w = k;
            default:          m_w = r;
        endcase
        if (we != 0) m_rf[wa] = wd;
    endtask

    initial begin
        vec_t        vt [13];
        int          cnt, ecnt;
        logic [4:0]  wa, ewa;
        logic [7:0]  wd, ewd;
        logic [8:0]  fa, efa;
        logic [8:0]  stack_pc [8];
        logic [11:0] op;

        vt[0]  = '{12'h1F0, 8'h02, 8'h01, 1, 8'h03, 8'h02, 9'h001};
        vt[1]  = '{12'h1D0, 8'h02, 8'h01, 0, 8'h00, 8'h03, 9'h001};
        vt[2]  = '{12'h2F1, 8'h00, 8'h01, 1, 8'h00, 8'h00, 9'h002};
        vt[3]  = '{12'h2F1, 8'h00, 8'h02, 1, 8'h01, 8'h00, 9'h001};
        vt[4]  = '{12'h4F2, 8'h00, 8'h80, 1, 8'h00, 8'h00, 9'h001};
        vt[5]  = '{12'h512, 8'h00, 8'h80, 1, 8'h81, 8'h00, 9'h001};
        vt[6]  = '{12'h7F2, 8'h00, 8'h80, 0, 8'h00, 8'h00, 9'h002};
        vt[7]  = '{12'h6F2, 8'h00, 8'h80, 0, 8'h00, 8'h00, 9'h001};
        vt[8]  = '{12'h033, 8'hA5, 8'h00, 1, 8'hA5, 8'hA5, 9'h001};
        vt[9]  = '{12'h000, 8'h33, 8'h00, 0, 8'h00, 8'h33, 9'h001};
        vt[10] = '{12'hB55, 8'h00, 8'h00, 0, 8'h00, 8'h00, 9'h155};
        vt[11] = '{12'h3D4, 8'h55, 8'hFF, 0, 8'h00, 8'h00, 9'h002};
        vt[12] = '{12'h9AB, 8'h12, 8'h00, 0, 8'h00, 8'h12, 9'h0AB};

        rst_n = 1'b0;
        en    = 1'b1;
        clear_mem();
        @(negedge clk);

        // Reset values
        do_reset();
        chk("rst_pc",     32'(pc_out),     32'h1FF);
        chk("rst_pmaddr", 32'(pm_addr),    32'h1FF);
        chk("rst_w",      32'(w_out),      32'h00);
        chk("rst_opcode", 32'(alu_opcode), 32'h000);
        chk("rst_we",     32'(rf_we),      32'h0);
        chk("rst_wdata",  32'(rf_wdata),   32'h00);

        // Reset vector and wrap to 0x000
        clear_mem();
        rom[9'h1FF] = 12'hC5A;
        do_reset();
        retire(cnt, wa, wd, fa);
        chk("wrap_fetch0", 32'(fa),     32'h1FF);
        chk("wrap_w",      32'(w_out),  32'h5A);
        chk("wrap_pc",     32'(pc_out), 32'h000);
        retire(cnt, wa, wd, fa);
        chk("wrap_fetch1", 32'(fa),     32'h000);

        // Table: MOVLW w0 at 0x1FF then the instruction under test at 0x000
        for (int i = 0; i < 13; i++) begin
            clear_mem();
            rom[9'h1FF] = {4'hC, vt[i].w0};
            rom[0]      = vt[i].instr;
            rf[vt[i].instr[4:0]] = vt[i].f0;
            do_reset();
            retire(cnt, wa, wd, fa);
            retire(cnt, wa, wd, fa);
            chk($sformatf("vec%0d_we", i), 32'(cnt),    32'(vt[i].exp_we));
            if (vt[i].exp_we != 0) begin
                chk($sformatf("vec%0d_wdata", i), 32'(wd), 32'(vt[i].exp_wd));
                chk($sformatf("vec%0d_waddr", i), 32'(wa), 32'(vt[i].instr[4:0]));
            end
            chk($sformatf("vec%0d_w", i),  32'(w_out),  32'(vt[i].exp_w));
            chk($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vt[i].exp_pc));
        end

        // Skip taken at 0x1FF wraps through 0x000 to 0x001
        clear_mem();
        rom[9'h1FF] = 12'h7F2;
        rf[5'h12]   = 8'h80;
        do_reset();
        retire(cnt, wa, wd, fa);
        chk("skipwrap_pc", 32'(pc_out), 32'h001);
        retire(cnt, wa, wd, fa);
        chk("skipwrap_fetch", 32'(fa), 32'h001);

        // Stack: three nested calls, three returns (third returns s2 again)
        clear_mem();
        rom[9'h001] = 12'h920;
        rom[9'h020] = 12'h930;
        rom[9'h030] = 12'h940;
        rom[9'h040] = 12'h811;
        rom[9'h031] = 12'h811;
        rom[9'h021] = 12'h811;
        stack_pc = '{9'h000, 9'h001, 9'h020, 9'h030, 9'h040, 9'h031, 9'h021, 9'h021};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            retire(cnt, wa, wd, fa);
            chk($sformatf("stack_pc%0d", i), 32'(pc_out), 32'(stack_pc[i]));
        end
        chk("stack_w", 32'(w_out), 32'h11);

        // Async reset while ADDWF d=1 is in EXEC
        clear_mem();
        rom[9'h1FF] = 12'hC02;
        rom[9'h000] = 12'h1F0;
        rf[5'h10]   = 8'h01;
        do_reset();
        retire(cnt, wa, wd, fa);
        @(posedge clk); @(negedge clk);
        @(posedge clk); #1;
        chk("arst_exec_we", 32'(rf_we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",     32'(rf_we),      32'h0);
        chk("arst_wdata",  32'(rf_wdata),   32'h00);
        chk("arst_pc",     32'(pc_out),     32'h1FF);
        chk("arst_pmaddr", 32'(pm_addr),    32'h1FF);
        chk("arst_w",      32'(w_out),      32'h00);
        chk("arst_opcode", 32'(alu_opcode), 32'h000);
        @(posedge clk); @(negedge clk);
        chk("arst_we_held", 32'(rf_we), 32'h0);
        chk("arst_w_held",  32'(w_out), 32'h00);

        // en=0 holds in FETCH
        en = 1'b0;
        clear_mem();
        rom[9'h1FF] = 12'hC77;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_pmaddr%0d", i), 32'(pm_addr), 32'h1FF);
        end
        chk("hold_pc", 32'(pc_out), 32'h1FF);

        // en dropped during LOAD: instruction completes, then stall
        en = 1'b1;
        @(posedge clk); @(negedge clk);
        en = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("late_en_w",  32'(w_out),  32'h77);
        chk("late_en_pc", 32'(pc_out), 32'h000);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        chk("stall_pc",     32'(pc_out),  32'h000);
        chk("stall_pmaddr", 32'(pm_addr), 32'h000);
        chk("stall_w",      32'(w_out),   32'h77);
        en = 1'b1;

        // Random program against the reference model
        for (int i = 0; i < 512; i++) begin
            op = 12'($urandom);
            if (op[11:8] >= 4'hD) op[11:8] = 4'hC;
            rom[i] = op;
        end
        for (int i = 0; i < 32; i++) begin
            rf[i]   = 8'($urandom);
            m_rf[i] = rf[i];
        end
        m_w  = 8'h00;
        m_pc = 9'h1FF;
        m_q  = '{9'h000, 9'h000};
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); @(negedge clk); end
                en = 1'b1;
            end
            efa = m_pc;
            model_step(ecnt, ewa, ewd);
            retire(cnt, wa, wd, fa);
            chk($sformatf("rnd%0d_fetch", n), 32'(fa),     32'(efa));
            chk($sformatf("rnd%0d_pc", n),    32'(pc_out), 32'(m_pc));
            chk($sformatf("rnd%0d_w", n),     32'(w_out),  32'(m_w));
            chk($sformatf("rnd%0d_we", n),    32'(cnt),    32'(ecnt));
            if (ecnt != 0) begin
                chk($sformatf("rnd%0d_waddr", n), 32'(wa), 32'(ewa));
                chk($sformatf("rnd%0d_wdata", n), 32'(wd), 32'(ewd));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pic10_seq_ctrl.md
# pic10_seq_ctrl

Instruction sequencer for the PIC10F200-compatible core. Fetches 12-bit instructions from program memory, drives the combinational byte ALU (`opcode10F200`: f, w, opcode -> R) and routes R to W or the file register. Handles GOTO/CALL/RETLW, MOVLW, BCF/BSF and skip instructions itself. Sits between program ROM, register file and ALU; one instruction retires every 3 clocks.

## Interface
- RESET_VEC, 9'h1FF, PC value after reset
- PC_W, 9, program counter width (fixed 9 for 10F200 map)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable, sampled only in FETCH
- pm_addr  out  9  program memory address (registered)
- pm_data  in  12  program word, valid in the cycle after pm_addr is presented (synchronous ROM)
- rf_addr  out  5  file register address = ir[4:0]
- rf_rdata  in  8  file register read data, combinational from rf_addr
- rf_wdata  out  8  file register write data
- rf_we  out  1  file register write strobe, single cycle
- alu_opcode  out  12  instruction word to ALU (= ir)
- alu_f  out  8  ALU f operand (= rf_rdata)
- alu_w  out  8  ALU w operand (= W)
- alu_r  in  8  ALU result, combinational
- w_out  out  8  W register (debug/observe)
- pc_out  out  9  current PC

## Operation
- FSM: FETCH -> LOAD -> EXEC -> FETCH.
- FETCH: pm_addr <= pc. If en=0, stay in FETCH; no other state change.
- LOAD: ir <= pm_data; pc <= pc+1 mod 512 (0x1FF -> 0x000).
- EXEC, decoded from ir:
  - ir[11:5]=0000000 (NOP/OPTION/SLEEP/CLRWDT/TRIS): no effect.
  - MOVWF (ir[11:5]=0000001): rf_we=1, rf_wdata=alu_r.
  - Byte ops (ir[11:10]=00, otherwise): d=ir[5]; d=1 -> rf_we=1, rf_wdata=alu_r; d=0 -> W <= alu_r.
  - DECFSZ (001011), INCFSZ (001111): writeback as above; if alu_r==0, pc <= pc+1 (skip).
  - BCF (0100)/BSF (0101): rf_wdata = rf_rdata with bit ir[7:5] cleared/set, rf_we=1; ALU result ignored.
  - BTFSC (0110)/BTFSS (0111): skip (pc <= pc+1) if bit ir[7:5] of rf_rdata is 0/1. No write.
  - MOVLW (1100): W <= ir[7:0].
  - RETLW (1000): W <= ir[7:0]; pc <= pop.
  - CALL (1001): push pc; pc <= {1'b0, ir[7:0]}.
  - GOTO (101x): pc <= ir[8:0].
- Stack: 2 levels, s1 top, s2 bottom. Push: s2<=s1, s1<=pc; a third push discards old s2. Pop: returns s1, s1<=s2, s2 unchanged (repeat pops return s2). No overflow/underflow flag.
- STATUS Z/C/DC: not maintained here (ALU/register file concern).

## Timing
- Reset (async, rst_n=0): state=FETCH, pc=RESET_VEC, pm_addr=RESET_VEC, ir=0, W=0, s1=s2=0, rf_we=0, rf_wdata=0; alu_opcode=0, w_out=0, pc_out=RESET_VEC.
- Reset asserted mid-instruction: no rf_we pulse and no W update for that instruction.
- Latency: fixed 3 cycles/instruction, skip included (skip costs no extra cycle).
- rf_we is high only during EXEC, exactly one cycle; rf_addr/rf_wdata stable in that cycle.
- ALU path combinational: rf_rdata -> alu_f -> alu_r -> rf_wdata/W within EXEC cycle.
- Skip at pc=0x1FF wraps: pc 0x1FF -> 0x000 (LOAD) -> 0x001 (skip).
- en deasserted during LOAD/EXEC: current instruction completes; stall starts at next FETCH.

## Structure
- pic10_pkg: state enum (FETCH, LOAD, EXEC), opcode field constants (MOVWF, DECFSZ, INCFSZ, BCF, BSF, BTFSC, BTFSS, MOVLW, RETLW, CALL, GOTO prefixes), RESET_VEC default.
- One sub-module: pic10_stack (2-level push/pop, 9-bit entries, async active-low reset).
- Decode and FSM in pic10_seq_ctrl; ALU stays external.

## Test plan
- Reset/wrap: ROM[0x1FF]=MOVLW 0x5A (0xC5A), ROM[0]=NOP -> after 3 clocks W=0x5A, pc_out=0x000; next fetch address 0x000.
- ALU writeback: W=0x02, f[0x10]=0x01, ADDWF 0x10,d=1 (0x1F0), ALU model R=0x03 -> rf_we one cycle, rf_addr=0x10, rf_wdata=0x03, W unchanged; same with d=0 (0x1D0) -> W=0x03, rf_we never high.
- Skip: f[0x11]=0x01, DECFSZ 0x11,1 (0x2F1) at pc=4 -> rf_wdata=0x00, next fetch at 6; with f=0x02 -> next fetch at 5.
- Bit ops: f[0x12]=0x80, BCF 0x12,7 (0x4F2) -> rf_wdata=0x00; BTFSS 0x12,7 on 0x80 (0x7F2) -> skip, no rf_we.
- Stack: CALL 0x20 at pc=1, CALL 0x30 at 0x20, CALL 0x40 at 0x30, three RETLW 0x11 -> returns to 0x31, 0x21, 0x21; W=0x11.
- Async reset during EXEC of ADDWF,d=1 -> no rf_we pulse, all outputs at reset values immediately, pc_out=0x1FF; en=0 holds in FETCH with pm_addr constant for 10 cycles.
